// File: rtl/dram_ring_writer_if.sv
// Sample-word stream into the DRAM ring writer.
// Producer drives the word; the writer returns in_ready.
interface dram_ring_writer_if;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   in_board;
    logic [6:0]   in_channel;
    logic [255:0] in_data;

    modport master (
        output in_valid, in_board, in_channel, in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_board, in_channel, in_data,
        output in_ready
    );
endinterface

// File: rtl/dram_ring_writer.sv
// Write side of the triggered readout: per-board ring offsets, trigger snapshot.
// FREEZE_ON_TRIGGER_EN: block new words while the trigger holdoff runs.
module dram_ring_writer #(
    parameter int NUM_BOARDS         = 8,
    parameter int CHANNELS_PER_BOARD = 125,
    parameter int CHANNEL_OFFSET_LEN = 14,
    parameter int BOARDS_X_OFFSETS   = CHANNEL_OFFSET_LEN * NUM_BOARDS,
    parameter int HOLDOFF_CYCLES     = 1000000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    dram_ring_writer_if.slave             in_if,
    output logic                          DRAM_Write_Enable,
    output logic [CHANNEL_OFFSET_LEN+10:0] DRAM_Write_Addr,
    output logic [255:0]                  DRAM_Write_Data,
    input  logic                          DRAM_Write_Ready,
    input  logic                          trig_in,
    input  logic [15:0]                   trig_time_stamp,
    output logic                          triggering_status,
    output logic [15:0]                   triggering_time_stamp,
    output logic [BOARDS_X_OFFSETS-1:0]   prev_channel_offsets,
    output logic                          holdoff_active,
    output logic [7:0]                    err_count
);

    localparam int CW = $clog2(HOLDOFF_CYCLES + 1);
    localparam logic [CHANNEL_OFFSET_LEN-1:0] OFF_ONE = 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(HOLDOFF_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = 1;

    typedef enum logic [1:0] {
        ARMED,
        FIRE,
        HOLDOFF
    } state_t;

    state_t  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [CHANNEL_OFFSET_LEN-1:0] offset_q [NUM_BOARDS];
    logic [CHANNEL_OFFSET_LEN-1:0] cur_off;
    logic [BOARDS_X_OFFSETS-1:0]   snap_now;

    logic accept;
    logic legal;
    logic last_ch;
    logic base_ready;

    assign cur_off = offset_q[in_if.in_board];
    assign legal   = (int'(in_if.in_board) < NUM_BOARDS) &&
                     (int'(in_if.in_channel) < CHANNELS_PER_BOARD);
    assign last_ch = int'(in_if.in_channel) == CHANNELS_PER_BOARD - 1;

    assign base_ready = !DRAM_Write_Enable || DRAM_Write_Ready;

`ifdef FREEZE_ON_TRIGGER_EN
    assign in_if.in_ready = base_ready && (state_q != HOLDOFF);
`else
    assign in_if.in_ready = base_ready;
`endif

    assign accept = in_if.in_valid && in_if.in_ready;

    always_comb begin
        snap_now = '0;
        for (int i = 0; i < NUM_BOARDS; i++) begin
            snap_now[i*CHANNEL_OFFSET_LEN +: CHANNEL_OFFSET_LEN] = offset_q[i];
        end
    end

    // Holding register; an illegal word still frees the slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            DRAM_Write_Enable <= 1'b0;
            DRAM_Write_Addr   <= '0;
            DRAM_Write_Data   <= '0;
        end else if (accept && legal) begin
            DRAM_Write_Enable <= 1'b1;
            DRAM_Write_Addr   <= {1'b0, in_if.in_board, in_if.in_channel, cur_off};
            DRAM_Write_Data   <= in_if.in_data;
        end else if (DRAM_Write_Ready) begin
            DRAM_Write_Enable <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BOARDS; i++) begin
                offset_q[i] <= '0;
            end
        end else if (accept && legal && last_ch) begin
            offset_q[in_if.in_board] <= cur_off + OFF_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (accept && !legal && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ARMED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ARMED: begin
                if (trig_in) state_d = FIRE;
            end
            FIRE: begin
                cnt_d   = CNT_LOAD;
                state_d = HOLDOFF;
            end
            HOLDOFF: begin
                if (cnt_q == '0) state_d = ARMED;
                else             cnt_d   = cnt_q - CNT_ONE;
            end
            default: state_d = ARMED;
        endcase
    end

    assign triggering_status = (state_q == FIRE);
    assign holdoff_active    = (state_q == HOLDOFF);

    // Registered offsets give the pre-increment view on a coincident trigger.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_channel_offsets  <= '0;
            triggering_time_stamp <= '0;
        end else if (state_q == ARMED && trig_in) begin
            prev_channel_offsets  <= snap_now;
            triggering_time_stamp <= trig_time_stamp;
        end
    end

endmodule

// File: tb/tb_dram_ring_writer.sv
// Directed bench for dram_ring_writer with a short trigger holdoff.
// Writes are tracked by a small commit monitor.
module tb_dram_ring_writer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         we;
    logic [24:0]  addr;
    logic [255:0] wdata;
    logic         rdy;
    logic         trig_in;
    logic [15:0]  ts;
    logic         tstat;
    logic [15:0]  tts;
    logic [111:0] prev;
    logic         hold;
    logic [7:0]   errc;

    int checks   = 0;
    int failures = 0;
    int wcount   = 0;
    logic [24:0] last_addr = '0;

    dram_ring_writer_if bus();

    dram_ring_writer #(.HOLDOFF_CYCLES(16)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .in_if                 (bus),
        .DRAM_Write_Enable     (we),
        .DRAM_Write_Addr       (addr),
        .DRAM_Write_Data       (wdata),
        .DRAM_Write_Ready      (rdy),
        .trig_in               (trig_in),
        .trig_time_stamp       (ts),
        .triggering_status     (tstat),
        .triggering_time_stamp (tts),
        .prev_channel_offsets  (prev),
        .holdoff_active        (hold),
        .err_count             (errc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && we && rdy) begin
            wcount    <= wcount + 1;
            last_addr <= addr;
        end
    end

    task automatic check(input string tag, input logic [255:0] obs,
                         input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [2:0] b, input logic [6:0] c,
                        input logic [255:0] d);
        bus.in_valid   = 1'b1;
        bus.in_board   = b;
        bus.in_channel = c;
        bus.in_data    = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [111:0] exp_prev;
        logic [255:0] da;
        logic [255:0] db;
        int w0;
        int pulses;
        int guard;

        rst_n = 1'b0;
        rdy = 1'b1;
        trig_in = 1'b0;
        ts = '0;
        bus.in_valid = 1'b0;
        bus.in_board = '0;
        bus.in_channel = '0;
        bus.in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_we", we, 0);
        check("rst_addr", addr, 0);
        check("rst_data", wdata, 0);
        check("rst_tstat", tstat, 0);
        check("rst_tts", tts, 0);
        check("rst_prev", prev, 0);
        check("rst_hold", hold, 0);
        check("rst_err", errc, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single word board 2 channel 5
        send(3'd2, 7'd5, {32{8'hA5}});
        bus.in_valid = 1'b0;
        check("first_we", we, 1);
        check("first_addr", addr, 25'h414000);
        check("first_data", wdata, {32{8'hA5}});
        check("first_ready", bus.in_ready, 1);

        // board 0: two full passes then channel 0
        for (int p = 0; p < 2; p++) begin
            for (int c = 0; c < 125; c++) begin
                send(3'd0, 7'(c), 256'(c));
            end
        end
        send(3'd0, 7'd0, 256'h77);
        check("b0_pass3_addr", addr, 25'h000002);
        send(3'd1, 7'd0, 256'h11);
        bus.in_valid = 1'b0;
        check("b1_addr", addr, 25'h200000);
        @(posedge clk);
        #1;

        // backpressure
        da = {8{32'hDEADBEEF}};
        db = {8{32'h0BADF00D}};
        w0 = wcount;
        rdy = 1'b0;
        send(3'd4, 7'd10, da);
        bus.in_channel = 7'd11;
        bus.in_data = db;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check("bp_ready", bus.in_ready, 0);
        check("bp_addr", addr, 25'h828000);
        check("bp_data", wdata, da);
        check("bp_nowrite", wcount, w0);
        rdy = 1'b1;
        @(posedge clk);
        #1;
        check("bp_one_write", wcount, w0 + 1);
        check("bp_commit_addr", last_addr, 25'h828000);
        check("bp_next_addr", addr, 25'h82C000);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("bp_two_writes", wcount, w0 + 2);

        // board 7 offset wrap
        for (int i = 0; i < 16384; i++) begin
            send(3'd7, 7'd124, 256'(i));
        end
        check("b7_last_addr", addr, 25'hFF3FFF);
        send(3'd7, 7'd0, 256'h5);
        bus.in_valid = 1'b0;
        check("b7_wrap_addr", addr, 25'hE00000);

        // trigger coincident with board 3 offset increment
        for (int i = 0; i < 9; i++) begin
            send(3'd3, 7'd124, 256'(i));
        end
        trig_in = 1'b1;
        ts = 16'h1234;
        send(3'd3, 7'd124, 256'h9);
        bus.in_valid = 1'b0;
        trig_in = 1'b0;
        exp_prev = '0;
        exp_prev[0 +: 14] = 14'd2;
        exp_prev[42 +: 14] = 14'd9;
        check("trig_pulse", tstat, 1);
        check("trig_ts", tts, 16'h1234);
        check("trig_prev", prev, exp_prev);
        @(posedge clk);
        #1;
        check("trig_pulse_end", tstat, 0);
        check("trig_hold_on", hold, 1);
        trig_in = 1'b1;
        ts = 16'h5678;
        pulses = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (tstat) pulses++;
        end
        check("holdoff_no_pulse", pulses, 0);
        check("holdoff_still", hold, 1);
        check("holdoff_ts_stable", tts, 16'h1234);
        check("holdoff_prev_stable", prev, exp_prev);
        @(posedge clk);
        #1;
        check("rearm_hold", hold, 0);
        check("rearm_no_pulse", tstat, 0);
        @(posedge clk);
        #1;
        trig_in = 1'b0;
        check("retrig_pulse", tstat, 1);
        check("retrig_ts", tts, 16'h5678);
        guard = 0;
        while ((hold || tstat) && guard < 40) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("retrig_done", hold, 0);

        // illegal words
        w0 = wcount;
        send(3'd0, 7'd125, 256'h1);
        check("ill_no_we", we, 0);
        send(3'd0, 7'd127, 256'h2);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("ill_err2", errc, 2);
        check("ill_no_write", wcount, w0);
        bus.in_valid = 1'b1;
        bus.in_channel = 7'd126;
        repeat (300) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("ill_err_sat", errc, 8'hFF);
        check("ill_no_write2", wcount, w0);

        // reset mid-operation
        rdy = 1'b0;
        trig_in = 1'b1;
        send(3'd3, 7'd1, 256'h3);
        bus.in_valid = 1'b0;
        trig_in = 1'b0;
        @(posedge clk);
        #1;
        check("pre_rst_we", we, 1);
        check("pre_rst_hold", hold, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_we", we, 0);
        check("mid_rst_hold", hold, 0);
        check("mid_rst_err", errc, 0);
        check("mid_rst_prev", prev, 0);
        rst_n = 1'b1;
        rdy = 1'b1;
        send(3'd3, 7'd0, 256'h4);
        bus.in_valid = 1'b0;
        check("post_rst_addr", addr, 25'h600000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
